// File: rtl/matrix_spi_pkg.sv
// Shared definitions for the LED matrix SPI frame transmitter:
// frame geometry, bit-counter width and the transmitter state encoding.
package matrix_spi_pkg;

  // 8 column-enable bits plus 8x8 row-off bits
  localparam int FRAME_BITS = 72;

  // Bit counter covers 0..FRAME_BITS-1 without wrapping
  localparam int BIT_CNT_W = 7;

  // Index of the final bit of a frame, in bit-counter width
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOW   = 2'd1,
    HIGH  = 2'd2,
    TRAIL = 2'd3
  } spi_tx_state_t;

endpackage

// File: rtl/matrix_spi_tick.sv
// Half-period timer for the SPI clock. Counts 0..CLK_DIV-1 and flags the
// last count with tick_o; clr_i restarts the count so every state entered
// by the transmitter lasts exactly CLK_DIV cycles.
module matrix_spi_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: restart on clear or at the end of a half-period
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/matrix_frame_spi_tx.sv
// SPI mode-0 transmitter for one 72-bit LED matrix frame. Raises load for
// the whole transfer, emits 72 sck pulses with data MSB first (data changes
// only on sck falling), holds a trailing low half-period and pulses done.
module matrix_frame_spi_tx
  import matrix_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  busy,
  output logic                  done,
  output logic                  sck,
  output logic                  sdo,
  output logic                  load
);

  spi_tx_state_t         state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  sck_q, sck_d;
  logic                  load_q, load_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tick;
  logic                  tick_clr;

  // Timer is held cleared while idle so the first LOW phase is full length;
  // every other state change happens on a tick, where the count wraps anyway.
  assign tick_clr = (state_q == IDLE) || tick;

  matrix_spi_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr_i (tick_clr),
    .tick_o(tick)
  );

  // Next-state and output decode for the framing state machine
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    sck_d     = sck_q;
    load_d    = load_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        sck_d  = 1'b0;
        load_d = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          shift_d   = frame;
          bit_cnt_d = '0;
          load_d    = 1'b1;
          busy_d    = 1'b1;
          state_d   = LOW;
        end
      end

      LOW: begin
        if (tick) begin
          sck_d   = 1'b1;
          state_d = HIGH;
        end
      end

      HIGH: begin
        if (tick) begin
          sck_d = 1'b0;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = TRAIL;
          end else begin
            // Next bit appears on sdo together with the sck falling edge
            shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            state_d   = LOW;
          end
        end
      end

      TRAIL: begin
        if (tick) begin
          // Clearing the shifter returns sdo to 0 for the idle line
          shift_d = '0;
          load_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset abandons any partial frame
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      sck_q     <= 1'b0;
      load_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      sck_q     <= sck_d;
      load_q    <= load_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sck  = sck_q;
  assign sdo  = shift_q[FRAME_BITS-1];
  assign load = load_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
